iram_loader: RTL

- Upstream program-load stage for the per-core instruction RAM array (N cores, 512 x 16-bit each).
- Consumes a byte stream from the host link receiver and assembles 16-bit instruction words.
- Writes those words into one selected core's IRAM, or into all IRAMs in parallel, starting at address 0.
- Holds each target core in reset while its image is being loaded.

---
 rtl/iram_loader_if.sv | 29 ++
 rtl/iram_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/iram_loader_if.sv
// Bus bundle between the host byte receiver, the loader and the IRAM array.
// master = loader side (consumes bytes, drives IRAM write port and status).
// slave  = environment side (drives bytes, observes writes and status).
interface iram_loader_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 9
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [N-1:0]      iram_write_en;
  logic [ADDR_W-1:0] iram_addr;
  logic [15:0]       iram_data;
  logic [N-1:0]      hold_cores;
  logic              busy;
  logic              load_done;
  logic              load_error;

  modport master (
    input  rx_valid, rx_data,
    output iram_write_en, iram_addr, iram_data,
    output hold_cores, busy, load_done, load_error
  );

  modport slave (
    output rx_valid, rx_data,
    input  iram_write_en, iram_addr, iram_data,
    input  hold_cores, busy, load_done, load_error
  );
endinterface

// File: rtl/iram_loader.sv
// Program loader: assembles a SEL/LEN/data byte frame into 16-bit words written to one or all core IRAMs.
// Latency: a word's write_en/addr/data appear the cycle after the edge that samples its low byte.
// Backpressure: none; every rx_valid byte is consumed, invalid frames are drained in SKIP states.
module iram_loader #(
  parameter int N      = 4,
  parameter int ADDR_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  iram_loader_if.master  bus
);

  localparam logic [16:0] MAX_LEN = 17'(1 << ADDR_W);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, SKIP_HI, SKIP_LO
  } state_t;

  state_t            state_q;
  logic [N-1:0]      mask_q;       // target cores of the current frame
  logic              sel_ok_q;     // SEL named a real core or broadcast
  logic [7:0]        len_hi_q;
  logic [ADDR_W-1:0] last_idx_q;   // L-1, index of the final word
  logic [ADDR_W-1:0] idx_q;        // current word index
  logic [7:0]        data_hi_q;
  logic [N-1:0]      we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic [N-1:0]      hold_q;
  logic              done_q;
  logic              err_q;

  logic [N-1:0]      mask_d;
  logic              sel_ok_d;
  logic [15:0]       len_d;
  logic              len_bad_d;
  logic [ADDR_W-1:0] last_idx_d;

  // Decode the incoming byte as a SEL and as the low length byte.
  always_comb begin
    mask_d   = '0;
    sel_ok_d = 1'b0;
    if (bus.rx_data == 8'hFF) begin
      mask_d   = '1;
      sel_ok_d = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.rx_data == 8'(i)) begin
          mask_d[i] = 1'b1;
          sel_ok_d  = 1'b1;
        end
      end
    end
    len_d      = {len_hi_q, bus.rx_data};
    len_bad_d  = (len_d == 16'd0) || ({1'b0, len_d} > MAX_LEN);
    last_idx_d = ADDR_W'(len_d - 16'd1);
  end

  // Frame FSM with registered IRAM write port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      sel_ok_q   <= 1'b0;
      len_hi_q   <= '0;
      last_idx_q <= '0;
      idx_q      <= '0;
      data_hi_q  <= '0;
      we_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      hold_q     <= '1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q   <= '0;
      done_q <= 1'b0;
      if (bus.rx_valid) begin
        case (state_q)
          IDLE: begin
            err_q    <= 1'b0;
            mask_q   <= mask_d;
            sel_ok_q <= sel_ok_d;
            // Target cores are held from the moment they are selected.
            hold_q   <= hold_q | mask_d;
            state_q  <= LEN_HI;
          end
          LEN_HI: begin
            len_hi_q <= bus.rx_data;
            state_q  <= LEN_LO;
          end
          LEN_LO: begin
            last_idx_q <= last_idx_d;
            idx_q      <= '0;
            if (len_bad_d) begin
              // Hold bits raised by SEL stay set: the core image is now suspect.
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else if (sel_ok_q) begin
              state_q <= DATA_HI;
            end else begin
              err_q   <= 1'b1;
              state_q <= SKIP_HI;
            end
          end
          DATA_HI: begin
            data_hi_q <= bus.rx_data;
            state_q   <= DATA_LO;
          end
          DATA_LO: begin
            we_q   <= mask_q;
            addr_q <= idx_q;
            data_q <= {data_hi_q, bus.rx_data};
            if (idx_q == last_idx_q) begin
              done_q  <= 1'b1;
              hold_q  <= hold_q & ~mask_q;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= DATA_HI;
            end
          end
          SKIP_HI: begin
            state_q <= SKIP_LO;
          end
          SKIP_LO: begin
            if (idx_q == last_idx_q) begin
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= SKIP_HI;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.iram_write_en = we_q;
  assign bus.iram_addr     = addr_q;
  assign bus.iram_data     = data_q;
  assign bus.hold_cores    = hold_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.load_done     = done_q;
  assign bus.load_error    = err_q;

endmodule
